// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
// Lets the CPU fetch port and data port share one single-port synchronous RAM
// (1-cycle read latency). The data port wins by default. A streak counter hands
// the RAM to a waiting fetch after MAX_STREAK back-to-back data grants.
// A registered owner steers returning read data to the port that issued the read.
module imem_dmem_arbiter #(
    parameter int XLEN       = 32,
    parameter int ALEN       = 32,
    parameter int MAX_STREAK = 4,
    parameter int SW         = 3
) (
    input  logic            clk,
    input  logic            rst,        // asynchronous, active-low
    // instruction fetch port
    input  logic            i_req,
    input  logic [ALEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    // data port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [ALEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    // RAM side
    output logic            mem_en,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IRD  = 2'd1,
        OWN_DRD  = 2'd2
    } owner_e;

    localparam logic [SW-1:0] STREAK_LIMIT = SW'(MAX_STREAK);
    localparam bit            FAIR_EN      = (MAX_STREAK != 0);

    owner_e          r_owner;
    owner_e          w_owner_nxt;
    logic [SW-1:0]   r_streak;
    logic [SW-1:0]   w_streak_nxt;
    logic            w_streak_full;

    // The streak has reached its limit; with fairness disabled it never blocks data.
    assign w_streak_full = FAIR_EN && (r_streak == STREAK_LIMIT);

    // Grant arbitration: data first unless a waiting fetch has used up its patience.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (d_req && !(i_req && w_streak_full)) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end else begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end

    // RAM command mux: granted port drives the RAM; idle cycles park on the fetch port.
    always_comb begin
        mem_en    = i_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_be    = 4'hF;
        mem_addr  = i_addr;
        mem_wdata = {XLEN{1'b0}};
        if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_be    = 4'hF;
            mem_addr  = i_addr;
            mem_wdata = {XLEN{1'b0}};
        end
    end

    // Next owner: whoever issued a read this cycle owns next cycle's RAM output.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (i_gnt) begin
            w_owner_nxt = OWN_IRD;
        end else if (d_gnt && !d_we) begin
            w_owner_nxt = OWN_DRD;
        end else begin
            w_owner_nxt = OWN_NONE;
        end
    end

    // Next streak: count data grants taken while fetch waits, saturating at the limit.
    always_comb begin
        w_streak_nxt = r_streak;
        if (i_gnt || !i_req) begin
            w_streak_nxt = {SW{1'b0}};
        end else if (d_gnt && !w_streak_full && (r_streak != STREAK_LIMIT)) begin
            w_streak_nxt = r_streak + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            w_streak_nxt = r_streak;
        end
    end

    // Owner and streak state; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner  <= OWN_NONE;
            r_streak <= {SW{1'b0}};
        end else begin
            r_owner  <= w_owner_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    assign i_rvalid = (r_owner == OWN_IRD);
    assign d_rvalid = (r_owner == OWN_DRD);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed testbench for imem_dmem_arbiter: one instance with MAX_STREAK=4 backed
// by a behavioural 1-cycle RAM, one with MAX_STREAK=0 for the no-fairness case.
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    logic        z_i_gnt, z_i_rvalid, z_d_gnt, z_d_rvalid;
    logic [31:0] z_i_rdata, z_d_rdata;
    logic        z_mem_en, z_mem_we;
    logic [3:0]  z_mem_be;
    logic [31:0] z_mem_addr, z_mem_wdata;

    logic [31:0] ram [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    imem_dmem_arbiter #(.XLEN(32), .ALEN(32), .MAX_STREAK(4), .SW(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_dmem_arbiter #(.XLEN(32), .ALEN(32), .MAX_STREAK(0), .SW(3)) dut_nofair (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(z_i_gnt), .i_rvalid(z_i_rvalid), .i_rdata(z_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(z_d_gnt), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_be(z_mem_be), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(32'h0000_0000)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM with byte-enabled writes and 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr[11:2]];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = 32'h0000_0000;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = 4'h0;
        d_addr  = 32'h0000_0000;
        d_wdata = 32'h0000_0000;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) ram[k] = 32'(k * 4);
        ram[32'h100 >> 2] = 32'hDEAD_BEEF;
        ram[32'h200 >> 2] = 32'h1122_3344;
        mem_rdata = 32'h0000_0000;
        idle_inputs();
        rst = 1'b0;
        repeat (2) next_cycle();

        // Reset state
        check_eq("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        check_eq("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check_eq("rst_owner", 32'(dut.r_owner), 32'd0);
        check_eq("rst_streak", 32'(dut.r_streak), 32'd0);
        rst = 1'b1;
        next_cycle();

        // Idle: RAM disabled, no write
        check_eq("idle_mem_en", {31'd0, mem_en}, 32'd0);
        check_eq("idle_mem_we", {31'd0, mem_we}, 32'd0);

        // Fetch alone, 10 sequential reads
        for (int k = 0; k < 10; k++) begin
            i_req  = 1'b1;
            i_addr = 32'(k * 4);
            #1;
            check_eq("fetch_i_gnt", {31'd0, i_gnt}, 32'd1);
            check_eq("fetch_d_gnt", {31'd0, d_gnt}, 32'd0);
            check_eq("fetch_mem_be", {28'd0, mem_be}, 32'hF);
            if (k > 0) begin
                check_eq("fetch_i_rvalid", {31'd0, i_rvalid}, 32'd1);
                check_eq("fetch_i_rdata", i_rdata, 32'((k - 1) * 4));
            end
            check_eq("fetch_d_rvalid", {31'd0, d_rvalid}, 32'd0);
            next_cycle();
        end
        idle_inputs();
        #1;
        check_eq("fetch_last_rvalid", {31'd0, i_rvalid}, 32'd1);
        check_eq("fetch_last_rdata", i_rdata, 32'h0000_0024);
        check_eq("fetch_last_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        next_cycle();

        // Simultaneous requests: data read wins
        i_req  = 1'b1;
        i_addr = 32'h0000_0000;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0100;
        #1;
        check_eq("both_d_gnt", {31'd0, d_gnt}, 32'd1);
        check_eq("both_i_gnt", {31'd0, i_gnt}, 32'd0);
        check_eq("both_mem_addr", mem_addr, 32'h0000_0100);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("both_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check_eq("both_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check_eq("both_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        next_cycle();

        // Both held for 12 cycles: D,D,D,D,I pattern; no-fairness instance always D
        i_req  = 1'b1;
        i_addr = 32'h0000_0040;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0100;
        for (int c = 1; c <= 12; c++) begin
            #1;
            check_eq("fair_i_gnt", {31'd0, i_gnt}, (c % 5 == 0) ? 32'd1 : 32'd0);
            check_eq("fair_d_gnt", {31'd0, d_gnt}, (c % 5 == 0) ? 32'd0 : 32'd1);
            check_eq("fair_streak_le4", {31'd0, (dut.r_streak <= 3'd4)}, 32'd1);
            check_eq("nofair_d_gnt", {31'd0, z_d_gnt}, 32'd1);
            check_eq("nofair_i_gnt", {31'd0, z_i_gnt}, 32'd0);
            if (c > 1) begin
                check_eq("fair_i_rvalid", {31'd0, i_rvalid}, ((c - 1) % 5 == 0) ? 32'd1 : 32'd0);
                check_eq("fair_d_rvalid", {31'd0, d_rvalid}, ((c - 1) % 5 == 0) ? 32'd0 : 32'd1);
                check_eq("fair_rdata", i_rdata, ((c - 1) % 5 == 0) ? 32'h0000_0040 : 32'hDEAD_BEEF);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Byte-enabled write then read back
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_addr  = 32'h0000_0200;
        d_wdata = 32'hAABB_CCDD;
        #1;
        check_eq("wr_d_gnt", {31'd0, d_gnt}, 32'd1);
        check_eq("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check_eq("wr_mem_be", {28'd0, mem_be}, 32'h3);
        check_eq("wr_mem_wdata", mem_wdata, 32'hAABB_CCDD);
        next_cycle();
        d_we = 1'b0;
        d_be = 4'hF;
        #1;
        check_eq("wr_no_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check_eq("rd_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("rd_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check_eq("rd_d_rdata", d_rdata, 32'h1122_CCDD);
        next_cycle();

        // Reset during an in-flight fetch
        i_req  = 1'b1;
        i_addr = 32'h0000_0040;
        #1;
        check_eq("rstf_i_gnt", {31'd0, i_gnt}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("rstf_pre_rvalid", {31'd0, i_rvalid}, 32'd1);
        #1;
        rst = 1'b0;
        i_req = 1'b0;
        #1;
        check_eq("rstf_i_rvalid_drop", {31'd0, i_rvalid}, 32'd0);
        check_eq("rstf_owner", 32'(dut.r_owner), 32'd0);
        check_eq("rstf_streak", 32'(dut.r_streak), 32'd0);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            check_eq("rstf_hold_rvalid", {31'd0, i_rvalid}, 32'd0);
        end
        rst = 1'b1;
        next_cycle();
        check_eq("rstf_post_rvalid", {31'd0, i_rvalid}, 32'd0);
        check_eq("rstf_post_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        i_req  = 1'b1;
        i_addr = 32'h0000_0040;
        #1;
        check_eq("rstf_refetch_gnt", {31'd0, i_gnt}, 32'd1);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("rstf_refetch_rvalid", {31'd0, i_rvalid}, 32'd1);
        check_eq("rstf_refetch_rdata", i_rdata, 32'h0000_0040);
        next_cycle();
        check_eq("rstf_refetch_done", {31'd0, i_rvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency) between the CPU instruction-fetch port and data port, so a unified program/data image can replace the separate instruction and data memories.
- Sits between PipelinedCPU and one RAM instance.
- Data port has priority; a streak counter guarantees fetch forward progress.
- Read data is routed back to the requester that issued it, via a registered owner.

Parameters:
- XLEN, 32, data width.
- ALEN, 32, address width.
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits; 0 disables fairness (data always wins).
- SW, 3, width of the streak counter; must hold MAX_STREAK.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch read request.
- i_addr  in  ALEN  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle (combinational).
- i_rvalid  out  1  i_rdata valid.
- i_rdata  out  XLEN  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  1=write, 0=read.
- d_be  in  4  byte enables for writes.
- d_addr  in  ALEN  data byte address.
- d_wdata  in  XLEN  write data.
- d_gnt  out  1  data accepted this cycle (combinational).
- d_rvalid  out  1  d_rdata valid (reads only).
- d_rdata  out  XLEN  data read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_be  out  4  RAM byte enables.
- mem_addr  out  ALEN  RAM address.
- mem_wdata  out  XLEN  RAM write data.
- mem_rdata  in  XLEN  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous deassert):
  - owner <- NONE; streak <- 0.
  - i_rvalid = d_rvalid = 0.
  - Any in-flight read is dropped: no rvalid after reset releases.
- Grant logic (combinational, same cycle as request):
  - Only d_req: d_gnt=1.
  - Only i_req: i_gnt=1.
  - Both requests: d_gnt=1, except when MAX_STREAK!=0 and streak==MAX_STREAK; then i_gnt=1.
  - At most one of i_gnt/d_gnt is 1 in any cycle.
- Memory command:
  - mem_en = i_gnt | d_gnt.
  - Address, we, be and wdata come from the granted port.
  - Fetch grant drives mem_we=0 and mem_be=4'hF.
  - No grant drives mem_en=0 and mem_we=0; other mem_* outputs hold the fetch-port values.
- Owner register, states NONE / IRD / DRD:
  - next = IRD if i_gnt; DRD if d_gnt & ~d_we; otherwise NONE. Data writes go to NONE.
  - i_rvalid = (owner==IRD); d_rvalid = (owner==DRD).
  - Read latency is exactly 1 cycle after grant.
  - i_rdata and d_rdata are both wired to mem_rdata; only the matching rvalid qualifies them.
- Streak counter:
  - Increments (saturating at MAX_STREAK) on a cycle with d_gnt & i_req.
  - Clears on i_gnt, and on any cycle with i_req=0.
  - Holds otherwise.
- Requesters hold req and payload stable until gnt. A request dropped before grant is legal and has no side effect.
- Back-to-back grants every cycle are allowed; throughput is 1 access per cycle.
- Address bits are passed through unmodified. Word alignment and byte-lane steering are the RAM's job.
- No combinational path from mem_rdata to any grant.

Test Plan:
- Fetch alone, 10 reads at 0x00, 0x04 … 0x24 with RAM preloaded with value = addr:
  - i_gnt=1 each cycle.
  - i_rvalid on the following cycles with i_rdata 0x00 … 0x24.
  - d_rvalid never asserted.
- Simultaneous i_req and d_req read at 0x100 (RAM 0xDEADBEEF), MAX_STREAK=4:
  - d_gnt=1, i_gnt=0.
  - Next cycle d_rvalid=1, d_rdata=0xDEADBEEF, i_rvalid=0.
- Both requests held continuously for 12 cycles, MAX_STREAK=4:
  - Grant pattern D,D,D,D,I repeating.
  - Fetch granted on cycles 5 and 10.
  - streak never exceeds 4.
- Same as above with MAX_STREAK=0:
  - d_gnt all 12 cycles, i_gnt never.
- Data write d_be=4'b0011, d_wdata=0xAABBCCDD to 0x200 (RAM 0x11223344), then data read of 0x200:
  - Write cycle: mem_we=1, no d_rvalid.
  - Read returns 0x1122CCDD.
- Fetch granted at 0x40, rst pulled low 2 ns after the edge, released after 2 cycles:
  - i_rvalid falls immediately and stays 0.
  - Owner and streak are 0.
  - First post-reset fetch returns correct data with 1-cycle latency.
